// File: rtl/uart_rx_fsm.sv
// UART receiver: 8N1 framing (8E1 with UART_RX_PARITY_EN defined), oversampled start/data/stop
// sampling, sticky ready flag with clear handshake, framing and overrun flags.
module uart_rx_fsm #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_enb,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic [7:0] data_out,
    output logic       rdy,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY    = 3'd5
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;
    logic [CW-1:0]          r_scnt;
    logic [CW-1:0]          w_scnt_nxt;
    logic [2:0]             r_bidx;
    logic [2:0]             w_bidx_nxt;
    logic [7:0]             r_shreg;
    logic [7:0]             w_shreg_nxt;
    logic                   w_good_c;
    logic                   w_bad_c;
    logic [7:0]             r_data;
    logic                   r_rdy;
    logic                   r_busy;
    logic                   r_ferr;
    logic                   r_ovr;
`ifdef UART_RX_PARITY_EN
    logic                   r_pbit;
    logic                   w_pbit_nxt;
    logic                   r_perr;
`endif

    // Metastability synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_scnt  <= '0;
            r_bidx  <= '0;
            r_shreg <= '0;
`ifdef UART_RX_PARITY_EN
            r_pbit  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
            r_bidx  <= w_bidx_nxt;
            r_shreg <= w_shreg_nxt;
`ifdef UART_RX_PARITY_EN
            r_pbit  <= w_pbit_nxt;
`endif
        end
    end

    // Next-state logic; everything advances only on oversample ticks
    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        w_bidx_nxt  = r_bidx;
        w_shreg_nxt = r_shreg;
        w_good_c    = 1'b0;
        w_bad_c     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_pbit_nxt  = r_pbit;
`endif
        if (rx_enb) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        w_scnt_nxt  = '0;
                        w_state_nxt = S_START;
                    end
                end
                S_START: begin
                    if (r_scnt == HALF_M1) begin
                        if (!w_rxs) begin
                            w_scnt_nxt  = '0;
                            w_bidx_nxt  = '0;
                            w_state_nxt = S_DATA;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_scnt_nxt = r_scnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_scnt == FULL_M1) begin
                        w_shreg_nxt[r_bidx] = w_rxs;
                        w_scnt_nxt          = '0;
                        if (r_bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = S_PARITY;
`else
                            w_state_nxt = S_STOP;
`endif
                        end else begin
                            w_bidx_nxt = r_bidx + 3'd1;
                        end
                    end else begin
                        w_scnt_nxt = r_scnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_scnt == FULL_M1) begin
                        w_pbit_nxt  = w_rxs;
                        w_scnt_nxt  = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_scnt_nxt = r_scnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_scnt == FULL_M1) begin
                        w_scnt_nxt = '0;
                        if (w_rxs) begin
                            w_good_c    = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_bad_c     = 1'b1;
                            w_state_nxt = S_WAIT_HIGH;
                        end
                    end else begin
                        w_scnt_nxt = r_scnt + 1'b1;
                    end
                end
                // A held-low line must return high before another start is accepted
                S_WAIT_HIGH: begin
                    if (w_rxs) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_scnt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Host-facing flags; a completion in the same cycle as rdy_clr keeps rdy set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_rdy  <= 1'b0;
            r_busy <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr <= 1'b0;
`endif
        end else begin
            r_busy <= (w_state_nxt == S_START) || (w_state_nxt == S_DATA) ||
`ifdef UART_RX_PARITY_EN
                      (w_state_nxt == S_PARITY) ||
`endif
                      (w_state_nxt == S_STOP);
            if (w_good_c) begin
                r_data <= r_shreg;
                r_rdy  <= 1'b1;
                r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_perr <= (^r_shreg) ^ r_pbit;
`endif
                if (rdy_clr) begin
                    r_ovr <= 1'b0;
                end else if (r_rdy) begin
                    r_ovr <= 1'b1;
                end
            end else if (rdy_clr) begin
                r_rdy <= 1'b0;
                r_ovr <= 1'b0;
            end
            if (w_bad_c) begin
                r_ferr <= 1'b1;
            end
        end
    end

    assign data_out   = r_data;
    assign rdy        = r_rdy;
    assign rx_busy    = r_busy;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- UART receiver that consumes the serial line produced by the transmit stage: one start bit, 8 data bits LSB first, one stop bit, idle-high line.
- Samples the line with an oversampling tick from the shared baud generator, validates start and stop bits, and delivers each byte with a sticky ready flag and clear handshake.
- Sits between the `rx` pad (or a loopback of `tx`) and the host-side consumer.

Parameters:
- OVERSAMPLE, 16: `rx_enb` ticks per bit period; even, ≥4.
- SYNC_STAGES, 2: flip-flops in the `rx` input synchronizer; ≥2.

Ports:
- `clk` input 1: single clock for all logic.
- `reset` input 1: asynchronous, active-high reset.
- `rx_enb` input 1: one-`clk` pulse at OVERSAMPLE × baud; FSM advances only on cycles with `rx_enb`=1.
- `rx` input 1: asynchronous serial line, idle high.
- `rdy_clr` input 1: one-`clk` pulse; consumer acknowledges `data_out`.
- `data_out` output 8: last correctly framed byte.
- `rdy` output 1: byte available; sticky until `rdy_clr`.
- `rx_busy` output 1: frame in progress.
- `frame_err` output 1: last frame had stop bit = 0.
- `overrun` output 1: a byte completed while `rdy`=1.

Behaviour:
- Reset (async): `data_out`=0, `rdy`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0; synchronizer flops=1; state=IDLE; counters=0.
- `rx` passes through SYNC_STAGES flops. Call the result `rxs`. The FSM uses only `rxs`.
- Tick counter `scnt` has width clog2(OVERSAMPLE). Bit index `bidx` is 3 bits. Both change only on `rx_enb` cycles.
- IDLE:
  - `rx_busy`=0.
  - On a tick with `rxs`=0: `scnt`←0, go to START.
- START:
  - `rx_busy`=1.
  - Count ticks. On the tick where `scnt` = OVERSAMPLE/2−1 (mid start bit), sample:
    - `rxs`=0: `scnt`←0, `bidx`←0, go to DATA.
    - `rxs`=1: false start (glitch), go to IDLE. No flags change.
- DATA:
  - On the tick where `scnt` = OVERSAMPLE−1: `shreg[bidx]`←`rxs`, `scnt`←0.
  - If `bidx`=7, go to STOP. Otherwise `bidx`←`bidx`+1.
- STOP: on the tick where `scnt` = OVERSAMPLE−1:
  - `rxs`=1:
    - `data_out`←`shreg`, `rdy`←1, `frame_err`←0.
    - If `rdy` was already 1: `overrun`←1.
    - Go to IDLE.
  - `rxs`=0:
    - `frame_err`←1; `data_out`, `rdy` and `overrun` unchanged.
    - Go to WAIT_HIGH.
- WAIT_HIGH (line break/framing recovery):
  - `rx_busy`=0.
  - Stay until a tick with `rxs`=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- `rdy_clr`: clears `rdy` and `overrun` on the next edge. If a byte completes in the same cycle, the set wins: `rdy`=1, and `overrun` is not set by that completion because the old byte was acknowledged.
- `frame_err` is sticky until the next good frame completes.
- Latency:
  - `rdy` rises on the `clk` edge of the mid-stop-bit tick.
  - A `rx` falling edge reaches `rxs` after SYNC_STAGES `clk` cycles.
- `rx_enb` stuck at 0 freezes the FSM. State, counters and outputs hold.
- Unused state encodings go to IDLE.

Optional Feature:
- Macro `UART_RX_PARITY_EN`.
- Defined:
  - Adds a PARITY state between DATA and STOP and an output `parity_err` (1 bit, reset 0).
  - The parity bit is sampled at mid-bit. Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch at good stop: `data_out` and `rdy` still update, `parity_err`←1. On a good frame with matching parity, `parity_err`←0.
  - A frame is 11 bit periods.
- Undefined: no PARITY state, no `parity_err` port, 10-bit frames.

Test Plan:
1. OVERSAMPLE=16, `rx_enb` every 4 clk. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → `data_out`=0xA5, `rdy`=1, `frame_err`=0, `overrun`=0; `rx_busy` high from start detect to stop sample.
2. Pulse `rx` low for 4 ticks only → FSM returns to IDLE at the mid-start sample; `rdy`=0, `rx_busy` back to 0, no flag change.
3. Send 0x3C with stop bit=0, then hold `rx` low 20 ticks, then high, then send 0x81 → `frame_err`=1 after first frame, no extra frame while low; after 0x81: `data_out`=0x81, `rdy`=1, `frame_err`=0.
4. Send 0x11 then 0x22 without `rdy_clr` → `data_out`=0x22, `overrun`=1. Pulse `rdy_clr` → `rdy`=0, `overrun`=0 next cycle. Also: `rdy_clr` on the exact completion cycle of a new byte → `rdy`=1, `overrun`=0.
5. Assert `reset` mid-DATA (after 4 bits of 0xFF), asynchronously between edges → all outputs 0 immediately. Then send 0x5A → received correctly.
6. (`UART_RX_PARITY_EN`) Send 0x07 with parity bit 0 → `parity_err`=1, `data_out`=0x07. Resend with parity bit 1 → `parity_err`=0.
